// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit
// Per-core fetch/decode sequencer. It drives one read port of the shared
// 256x8 instruction memory, owns the core's program counter, and resolves
// the two-byte JUMNZ branch. It consumes the EN0-EN3/ENALL core-select
// opcodes itself, issues datapath opcodes over a valid/ready handshake,
// and halts on END.
// Optional feature macro: IFU_ILLEGAL_TRAP_EN. When it is defined, an
// undefined opcode sets the sticky `illegal` flag and halts. When it is
// not defined, an undefined opcode is a NOP and `illegal` is tied to 0.
module instruction_fetch_unit #(
    parameter int unsigned CORE_ID    = 0,
    parameter logic [7:0]  START_ADDR = 8'd0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    output logic [7:0] addr,
    input  logic [7:0] instruction,
    input  logic       z_flag,
    output logic       op_valid,
    output logic [7:0] opcode,
    input  logic       op_ready,
    output logic       core_en,
    output logic       halted,
    output logic       illegal
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_OPND_FETCH,
        S_OPND_DECODE,
        S_HALT
    } state_t;

    localparam logic [7:0] OP_EN0   = 8'd3;
    localparam logic [7:0] OP_EN3   = 8'd6;
    localparam logic [7:0] OP_ENALL = 8'd7;
    localparam logic [7:0] OP_END   = 8'd38;
    localparam logic [7:0] OP_JUMNZ = 8'd40;
    // The ENn opcode that selects this particular core.
    localparam logic [7:0] EN_SELF  = 8'(CORE_ID + 32'd3);

    // Opcodes that are handed to the datapath: 8, 9 and 11..36.
    function automatic logic is_datapath_op(input logic [7:0] op);
        return (op == 8'd8) || (op == 8'd9) || ((op >= 8'd11) && (op <= 8'd36));
    endfunction

    state_t     state, state_n;
    logic [7:0] pc, pc_n;
    logic [7:0] addr_n;
    logic [7:0] opcode_n;
    logic       core_en_n;
    logic [7:0] pc_inc;

`ifdef IFU_ILLEGAL_TRAP_EN
    logic illegal_q, illegal_n;
`endif

    // The PC wraps modulo 256, so a JUMNZ at 255 reads its operand from 0.
    assign pc_inc = pc + 8'd1;

    // Next-state, next-PC and next-address decode for the fetch sequencer.
    always_comb begin
        // NOTE: every signal gets its hold value first, so that a branch
        // which does not mention a signal leaves it unchanged instead of
        // inferring a latch.
        state_n   = state;
        pc_n      = pc;
        addr_n    = addr;
        opcode_n  = opcode;
        core_en_n = core_en;
`ifdef IFU_ILLEGAL_TRAP_EN
        illegal_n = illegal_q;
`endif
        case (state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    pc_n      = START_ADDR;
                    addr_n    = START_ADDR;
                    core_en_n = 1'b1;
                    state_n   = S_FETCH;
                end
            end
            S_FETCH: begin
                state_n = S_DECODE;
            end
            S_DECODE: begin
                // Most opcodes fall through to the next sequential fetch.
                state_n = S_FETCH;
                pc_n    = pc_inc;
                addr_n  = pc_inc;
                if ((instruction >= OP_EN0) && (instruction <= OP_EN3)) begin
                    core_en_n = (instruction == EN_SELF);
                end else if (instruction == OP_ENALL) begin
                    core_en_n = 1'b1;
                end else if (instruction == OP_JUMNZ) begin
                    // The operand sits at pc+1 and is fetched whether or not
                    // this core is selected.
                    state_n = S_OPND_FETCH;
                end else if (instruction == OP_END) begin
                    if (core_en) begin
                        state_n = S_HALT;
                        pc_n    = pc;
                        addr_n  = addr;
                    end
                end else if (is_datapath_op(instruction)) begin
                    if (core_en) begin
                        state_n  = S_ISSUE;
                        opcode_n = instruction;
                        pc_n     = pc;
                        addr_n   = addr;
                    end
                end else begin
`ifdef IFU_ILLEGAL_TRAP_EN
                    // Undefined opcodes trap even when this core is deselected.
                    state_n   = S_HALT;
                    pc_n      = pc;
                    addr_n    = addr;
                    illegal_n = 1'b1;
`endif
                end
            end
            S_ISSUE: begin
                // The PC moves only on the edge where the datapath accepts.
                if (op_ready) begin
                    state_n = S_FETCH;
                    pc_n    = pc_inc;
                    addr_n  = pc_inc;
                end
            end
            S_OPND_FETCH: begin
                state_n = S_OPND_DECODE;
            end
            S_OPND_DECODE: begin
                // A non-zero accumulator takes the branch to the operand address.
                pc_n    = z_flag ? pc_inc : instruction;
                addr_n  = pc_n;
                state_n = S_FETCH;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // Sequencer registers; a synchronous reset aborts any instruction in flight.
    always_ff @(posedge clock) begin
        // NOTE: sequential state is updated with non-blocking assignments
        // only, so every register samples pre-edge values regardless of
        // the order of the statements.
        if (reset) begin
            state   <= S_IDLE;
            pc      <= 8'd0;
            addr    <= 8'd0;
            opcode  <= 8'd0;
            core_en <= 1'b1;
        end else begin
            state   <= state_n;
            pc      <= pc_n;
            addr    <= addr_n;
            opcode  <= opcode_n;
            core_en <= core_en_n;
        end
    end

`ifdef IFU_ILLEGAL_TRAP_EN
    // Sticky illegal-opcode flag; only reset clears it.
    always_ff @(posedge clock) begin
        if (reset) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_n;
        end
    end

    assign illegal = illegal_q;
`else
    assign illegal = 1'b0;
`endif

    assign op_valid = (state == S_ISSUE);
    assign halted   = (state == S_HALT);

endmodule
